// File: rtl/trace_plotter.sv
// Scrolling-trace framebuffer writer: each accepted sample erases one column of
// its channel's half-screen, then draws a vertical segment from the previous point.
module trace_plotter #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned COLOR_WIDTH = 9,
  parameter logic [COLOR_WIDTH-1:0] BG_COLOR  = COLOR_WIDTH'(0),
  parameter logic [COLOR_WIDTH-1:0] ECG_COLOR = COLOR_WIDTH'(1),
  parameter logic [COLOR_WIDTH-1:0] EMG_COLOR = COLOR_WIDTH'(2)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [11:0]            sample_data,
  input  logic                   channel,
  output logic [ADDR_WIDTH-1:0]  fb_addr,
  output logic [COLOR_WIDTH-1:0] fb_data,
  output logic                   fb_wEn
);

  localparam int unsigned HalfRows = HEIGHT / 2;
  localparam int unsigned ColW     = $clog2(WIDTH);
  localparam int unsigned RowW     = $clog2(HEIGHT);

  typedef enum logic [1:0] {StIdle, StClear, StDraw, StAdvance} state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   ch_q, ch_d;
  logic [RowW-1:0]        row_q, row_d;
  logic [RowW-1:0]        y_q, y_d;
  logic [RowW-1:0]        lo_q, lo_d;
  logic [RowW-1:0]        hi_q, hi_d;
  logic [ColW-1:0]        col_q [2];
  logic [ColW-1:0]        col_d [2];
  logic [RowW-1:0]        prev_q [2];
  logic [RowW-1:0]        prev_d [2];
  logic [1:0]             pv_q, pv_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COLOR_WIDTH-1:0] data_q, data_d;
  logic                   wen_q, wen_d;

  logic [7:0]      s_clamped;
  logic [RowW-1:0] base_in, base_cur, row_new, prev_in;
  logic            single;

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [ColW-1:0] c,
                                                     input logic [RowW-1:0] y);
    return ADDR_WIDTH'(c) + ADDR_WIDTH'(WIDTH) * ADDR_WIDTH'(y);
  endfunction

  always_comb begin
    s_clamped = (sample_data[11:4] > 8'(HalfRows - 1)) ? 8'(HalfRows - 1) : sample_data[11:4];
    base_in   = channel ? RowW'(HalfRows) : '0;
    base_cur  = ch_q ? RowW'(HalfRows) : '0;
    row_new   = base_in + RowW'(HalfRows - 1) - RowW'(s_clamped);
    prev_in   = prev_q[channel];
    // Column 0 never joins back to column WIDTH-1, so it always starts fresh.
    single    = !(pv_q[channel] && (col_q[channel] != '0));
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    ch_d    = ch_q;
    row_d   = row_q;
    y_d     = y_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    col_d   = col_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = 1'b0;

    case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (sample_valid && ready_q) begin
          ready_d = 1'b0;
          ch_d    = channel;
          row_d   = row_new;
          lo_d    = (single || row_new < prev_in) ? row_new : prev_in;
          hi_d    = (single || row_new > prev_in) ? row_new : prev_in;
          // First erase pixel goes out on the handshake edge itself.
          wen_d   = 1'b1;
          addr_d  = pix_addr(col_q[channel], base_in);
          data_d  = BG_COLOR;
          y_d     = base_in + RowW'(1);
          state_d = StClear;
        end
      end
      StClear: begin
        wen_d  = 1'b1;
        addr_d = pix_addr(col_q[ch_q], y_q);
        data_d = BG_COLOR;
        if (y_q == base_cur + RowW'(HalfRows - 1)) begin
          y_d     = lo_q;
          state_d = StDraw;
        end else begin
          y_d = y_q + RowW'(1);
        end
      end
      StDraw: begin
        wen_d  = 1'b1;
        addr_d = pix_addr(col_q[ch_q], y_q);
        data_d = ch_q ? EMG_COLOR : ECG_COLOR;
        if (y_q == hi_q) begin
          state_d = StAdvance;
        end else begin
          y_d = y_q + RowW'(1);
        end
      end
      StAdvance: begin
        prev_d[ch_q] = row_q;
        pv_d[ch_q]   = 1'b1;
        col_d[ch_q]  = (col_q[ch_q] == ColW'(WIDTH - 1)) ? '0 : col_q[ch_q] + ColW'(1);
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      ch_q    <= 1'b0;
      row_q   <= '0;
      y_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      col_q   <= '{default: '0};
      prev_q  <= '{default: '0};
      pv_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ch_q    <= ch_d;
      row_q   <= row_d;
      y_q     <= y_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      col_q   <= col_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
    end
  end

  assign sample_ready = ready_q;
  assign fb_addr      = addr_q;
  assign fb_data      = data_q;
  assign fb_wEn       = wen_q;

endmodule

// File: tb/tb_trace_plotter.sv
// Bench for trace_plotter: a full-width instance for the main vectors and a narrow
// instance (8 columns) so the column wrap is reachable in few cycles.
module tb_trace_plotter;

  localparam int WM = 640;
  localparam int WS = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        channel = 1'b0;
  logic [11:0] sample_data = '0;
  logic        sel = 1'b0;

  logic        valid_m, valid_s, rdy_m, rdy_s, wen_m, wen_s;
  logic [19:0] addr_m, addr_s;
  logic [8:0]  data_m, data_s;
  logic        rdy, wen;
  logic [19:0] addr;
  logic [8:0]  data;

  assign valid_m = valid & ~sel;
  assign valid_s = valid & sel;
  assign rdy     = sel ? rdy_s : rdy_m;
  assign wen     = sel ? wen_s : wen_m;
  assign addr    = sel ? addr_s : addr_m;
  assign data    = sel ? data_s : data_m;

  trace_plotter #(.WIDTH(WM)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (valid_m),
    .sample_ready (rdy_m),
    .sample_data  (sample_data),
    .channel      (channel),
    .fb_addr      (addr_m),
    .fb_data      (data_m),
    .fb_wEn       (wen_m)
  );

  trace_plotter #(.WIDTH(WS)) u_dut_narrow (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (valid_s),
    .sample_ready (rdy_s),
    .sample_data  (sample_data),
    .channel      (channel),
    .fb_addr      (addr_s),
    .fb_data      (data_s),
    .fb_wEn       (wen_s)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    logic        ch;
    logic [11:0] d;
    int          row;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   m_col[2][2];
  int   m_prev[2][2];
  bit   m_pv[2][2];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        m_col[d][c]  = 0;
        m_prev[d][c] = 0;
        m_pv[d][c]   = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_wen", int'(wen_m), 0);
    check("rst_ready", int'(rdy_m), 0);
    check("rst_addr", int'(addr_m), 0);
    check("rst_data", int'(data_m), 0);
    check("rst_ready_narrow", int'(rdy_s), 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", int'(rdy_m), 1);
    check("ready_after_reset_narrow", int'(rdy_s), 1);
    clear_model();
  endtask

  // Pushes every expected write, offers the sample, then scores writes until ready returns.
  task automatic send(input logic ch, input logic [11:0] d, input int exp_row, input string tag);
    int  di;
    int  w;
    int  col;
    int  base;
    int  lo;
    int  hi;
    int  n;
    int  cyc;
    bit  done;
    wr_t e;
    di   = int'(sel);
    w    = sel ? WS : WM;
    col  = m_col[di][ch];
    base = ch ? 240 : 0;
    exp_q.delete();
    for (int y = 0; y < 240; y++) exp_q.push_back('{col + w * (base + y), 0});
    if (m_pv[di][ch] && col != 0) begin
      lo = (m_prev[di][ch] < exp_row) ? m_prev[di][ch] : exp_row;
      hi = (m_prev[di][ch] > exp_row) ? m_prev[di][ch] : exp_row;
    end else begin
      lo = exp_row;
      hi = exp_row;
    end
    for (int y = lo; y <= hi; y++) exp_q.push_back('{col + w * y, ch ? 2 : 1});
    n = hi - lo + 1;

    cyc = 0;
    @(negedge clock);
    while (!rdy && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    if (!rdy) begin
      check({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    valid       = 1'b1;
    channel     = ch;
    sample_data = d;
    @(posedge clock);
    // Scramble inputs and keep valid high: the block must ignore both while busy.
    #1;
    channel     = ~ch;
    sample_data = ~d;

    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      if (wen) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_write_addr"}, int'(addr), -1);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_addr_c%0d", tag, cyc), int'(addr), e.addr);
          check($sformatf("%s_data_c%0d", tag, cyc), int'(data), e.data);
        end
      end
      if (rdy) begin
        done  = 1'b1;
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    check({tag, "_ready_cycle"}, cyc, 242 + n);
    check({tag, "_missing_writes"}, exp_q.size(), 0);

    m_prev[di][ch] = exp_row;
    m_pv[di][ch]   = 1'b1;
    m_col[di][ch]  = (col == w - 1) ? 0 : col + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 12'h800, 111};
    vecs[1] = '{1'b0, 12'hA00, 79};
    vecs[2] = '{1'b1, 12'h000, 479};
    vecs[3] = '{1'b0, 12'hFFF, 0};
    vecs[4] = '{1'b1, 12'hEF0, 240};
    vecs[5] = '{1'b1, 12'hF00, 240};
    vecs[6] = '{1'b0, 12'h010, 238};
    vecs[7] = '{1'b0, 12'h00F, 239};

    sel = 1'b0;
    do_reset();
    foreach (vecs[i]) send(vecs[i].ch, vecs[i].d, vecs[i].row, $sformatf("vec%0d", i));

    // Reset on the 100th erase write of column 2.
    do_reset();
    send(1'b0, 12'h800, 111, "pre0");
    send(1'b0, 12'h700, 127, "pre1");
    @(negedge clock);
    valid       = 1'b1;
    channel     = 1'b0;
    sample_data = 12'h400;
    @(posedge clock);
    #1;
    valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (k == 1 || k == 100) begin
        check($sformatf("midrst_wen_c%0d", k), int'(wen_m), 1);
        check($sformatf("midrst_addr_c%0d", k), int'(addr_m), 2 + WM * (k - 1));
      end
    end
    reset = 1'b1;
    @(negedge clock);
    check("midrst_wen_off", int'(wen_m), 0);
    check("midrst_ready_low", int'(rdy_m), 0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_ready_back", int'(rdy_m), 1);
    clear_model();
    send(1'b0, 12'h400, 175, "post_rst");

    // Column wrap on the narrow instance: 9th sample lands back in column 0.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < WS; i++) begin
      if (i % 2 == 0) send(1'b0, 12'h500, 159, $sformatf("wrap%0d", i));
      else            send(1'b0, 12'hA00, 79, $sformatf("wrap%0d", i));
    end
    check("wrap_model_col", m_col[1][0], 0);
    send(1'b0, 12'h300, 191, "wrap_col0");
    sel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
